// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of flip-flops sharing one run-time mode (JK, SR, D or T),
// with sync clear, parallel load, enable, change reporting and a sticky SR-conflict flag.
module jk_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       sclr,
  input  logic                       load,
  input  logic [WIDTH-1:0]           d_load,
  input  logic [WIDTH-1:0]           j,
  input  logic [WIDTH-1:0]           k,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qn,
  output logic [WIDTH-1:0]           changed,
  output logic [$clog2(WIDTH+1)-1:0] chg_cnt,
  output logic                       sr_err,
  input  logic                       err_clr
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
  logic             sr_err_q, sr_err_d;
  logic             sr_set;

  assign mode_sel = mode_e'(mode);

  // Next-state selection: sclr > load > en > hold.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    q_d    = q_q;
    sr_set = 1'b0;
    if (sclr) begin
      q_d = '0;
    end else if (load) begin
      q_d = d_load;
    end else if (en) begin
      unique case (mode_sel)
        MODE_JK: q_d = (j & ~q_q) | (~k & q_q);
        // S=R=1 keeps the bit as it was; the conflict is only flagged.
        MODE_SR: begin
          q_d    = (j & ~k) | (q_q & (j | ~k));
          sr_set = |(j & k);
        end
        MODE_D:  q_d = j;
        MODE_T:  q_d = q_q ^ j;
      endcase
    end
  end

  always_comb begin
    changed_d = q_d ^ q_q;
    chg_cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      chg_cnt_d = chg_cnt_d + CNT_W'(changed_d[i]);
    end
  end

  // A new conflict on the same edge as err_clr keeps the flag set.
  always_comb begin
    sr_err_d = sr_err_q;
    if (sr_set) begin
      sr_err_d = 1'b1;
    end else if (err_clr) begin
      sr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      q_q       <= RESET_VAL;
      changed_q <= '0;
      chg_cnt_q <= '0;
      sr_err_q  <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      chg_cnt_q <= chg_cnt_d;
      sr_err_q  <= sr_err_d;
    end
  end

  assign q       = q_q;
  assign qn      = ~q_q;
  assign changed = changed_q;
  assign chg_cnt = chg_cnt_q;
  assign sr_err  = sr_err_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: directed scenarios plus randomized
// edges compared against a truth-table reference model.
module tb_jk_reg_bank;

  localparam int         W     = 8;
  localparam logic [7:0] RST_V = 8'hA5;

  logic         clk = 1'b0;
  logic         reset, en, sclr, load, err_clr;
  logic [1:0]   mode;
  logic [W-1:0] d_load, j, k;
  logic [W-1:0] q, qn, changed;
  logic [3:0]   chg_cnt;
  logic         sr_err;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W-1:0] m_q;
  logic         m_err;

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(RST_V)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sclr(sclr), .load(load),
    .d_load(d_load), .j(j), .k(k), .q(q), .qn(qn), .changed(changed),
    .chg_cnt(chg_cnt), .sr_err(sr_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; mode = 0; sclr = 0; load = 0; err_clr = 0;
    d_load = 0; j = 0; k = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #2 reset = 1;
    #1;
    if ({q, qn, changed, chg_cnt, sr_err} !== {8'hA5, 8'h5A, 8'h00, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_async got q=%h qn=%h chg=%h cnt=%0d err=%b want q=a5 qn=5a chg=00 cnt=0 err=0",
               q, qn, changed, chg_cnt, sr_err);
    end
    total++;
    en = 1; mode = 2'b11; j = 8'hFF;
    tick();
    if ({q, changed, chg_cnt} !== {8'hA5, 8'h00, 4'd0}) begin
      bad++;
      $display("FAIL reset_hold got q=%h chg=%h cnt=%0d want q=a5 chg=00 cnt=0", q, changed, chg_cnt);
    end
    total++;
    idle_inputs();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_jk();
    @(negedge clk);
    en = 1; mode = 2'b00; j = 8'hF0; k = 8'h0F;
    tick();
    if ({q, changed, chg_cnt} !== {8'hF0, 8'h55, 4'd4}) begin
      bad++;
      $display("FAIL jk_set_reset got q=%h chg=%h cnt=%0d want q=f0 chg=55 cnt=4", q, changed, chg_cnt);
    end
    total++;
    j = 8'hFF; k = 8'hFF;
    tick();
    if ({q, qn, changed, chg_cnt} !== {8'h0F, 8'hF0, 8'hFF, 4'd8}) begin
      bad++;
      $display("FAIL jk_toggle got q=%h qn=%h chg=%h cnt=%0d want q=0f qn=f0 chg=ff cnt=8",
               q, qn, changed, chg_cnt);
    end
    total++;
  endtask

  task automatic test_sr();
    idle_inputs(); sclr = 1;
    tick();
    sclr = 0; en = 1; mode = 2'b01; j = 8'h81; k = 8'h01;
    tick();
    if ({q, sr_err} !== {8'h80, 1'b1}) begin
      bad++;
      $display("FAIL sr_conflict got q=%h err=%b want q=80 err=1", q, sr_err);
    end
    total++;
    j = 0; k = 0; err_clr = 1;
    tick();
    if ({q, sr_err, changed} !== {8'h80, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL sr_err_clear got q=%h err=%b chg=%h want q=80 err=0 chg=00", q, sr_err, changed);
    end
    total++;
    j = 8'h02; k = 8'h02;
    tick();
    if ({q, sr_err} !== {8'h80, 1'b1}) begin
      bad++;
      $display("FAIL sr_set_beats_clr got q=%h err=%b want q=80 err=1", q, sr_err);
    end
    total++;
  endtask

  task automatic test_priority();
    // SR conflict pre-empted by sclr must not raise the flag; err_clr clears it
    idle_inputs();
    sclr = 1; load = 1; d_load = 8'h3C; en = 1; mode = 2'b01; j = 8'hFF; k = 8'hFF; err_clr = 1;
    tick();
    if ({q, sr_err} !== {8'h00, 1'b0}) begin
      bad++;
      $display("FAIL prio_sclr got q=%h err=%b want q=00 err=0", q, sr_err);
    end
    total++;
    sclr = 0; err_clr = 0; en = 0;
    tick();
    if ({q, sr_err, chg_cnt} !== {8'h3C, 1'b0, 4'd4}) begin
      bad++;
      $display("FAIL prio_load got q=%h err=%b cnt=%0d want q=3c err=0 cnt=4", q, sr_err, chg_cnt);
    end
    total++;
    load = 0; j = 8'hFF;
    tick();
    if ({q, changed, chg_cnt} !== {8'h3C, 8'h00, 4'd0}) begin
      bad++;
      $display("FAIL prio_hold got q=%h chg=%h cnt=%0d want q=3c chg=00 cnt=0", q, changed, chg_cnt);
    end
    total++;
  endtask

  task automatic test_modes();
    idle_inputs();
    en = 1; mode = 2'b10; j = 8'hC3; k = 8'hFF;
    tick();
    if ({q, chg_cnt} !== {8'hC3, 4'd8}) begin
      bad++;
      $display("FAIL mode_d got q=%h cnt=%0d want q=c3 cnt=8", q, chg_cnt);
    end
    total++;
    mode = 2'b11; j = 8'h0F; k = 8'hAA;
    tick();
    if ({q, changed, chg_cnt} !== {8'hCC, 8'h0F, 4'd4}) begin
      bad++;
      $display("FAIL mode_t got q=%h chg=%h cnt=%0d want q=cc chg=0f cnt=4", q, changed, chg_cnt);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    en = 1; mode = 2'b11; j = 8'hFF;
    tick();
    tick();
    #2 reset = 1;
    #1;
    if ({q, qn, changed, chg_cnt, sr_err} !== {8'hA5, 8'h5A, 8'h00, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid got q=%h qn=%h chg=%h cnt=%0d err=%b want q=a5 qn=5a chg=00 cnt=0 err=0",
               q, qn, changed, chg_cnt, sr_err);
    end
    total++;
    @(negedge clk);
    reset = 0;
    tick();
    if ({q, qn, changed, chg_cnt} !== {8'h5A, 8'hA5, 8'hFF, 4'd8}) begin
      bad++;
      $display("FAIL reset_release got q=%h qn=%h chg=%h cnt=%0d want q=5a qn=a5 chg=ff cnt=8",
               q, qn, changed, chg_cnt);
    end
    total++;
    m_q   = 8'h5A;
    m_err = 1'b0;
  endtask

  // Reference: each bit follows the mode's truth table; priority sclr > load > en.
  task automatic test_random();
    logic [W-1:0] exp_q, exp_chg;
    int           exp_cnt;
    logic         conflict;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2 reset = 1;
        #1;
        if ({q, changed, chg_cnt, sr_err} !== {RST_V, 8'h00, 4'd0, 1'b0}) begin
          bad++;
          $display("FAIL rnd_reset n=%0d got q=%h chg=%h cnt=%0d err=%b", n, q, changed, chg_cnt, sr_err);
        end
        total++;
        #1 reset = 0;
        m_q   = RST_V;
        m_err = 1'b0;
      end
      en      = $urandom_range(0, 3) != 0;
      mode    = 2'($urandom_range(0, 3));
      sclr    = $urandom_range(0, 15) == 0;
      load    = $urandom_range(0, 9) == 0;
      err_clr = $urandom_range(0, 5) == 0;
      d_load  = 8'($urandom);
      j       = 8'($urandom);
      k       = 8'($urandom);

      exp_q    = m_q;
      conflict = 1'b0;
      if (sclr) exp_q = 0;
      else if (load) exp_q = d_load;
      else if (en) begin
        for (int b = 0; b < W; b++) begin
          case (mode)
            2'd0: exp_q[b] = ({j[b], k[b]} == 2'b10) ? 1'b1 :
                             ({j[b], k[b]} == 2'b01) ? 1'b0 :
                             ({j[b], k[b]} == 2'b11) ? !m_q[b] : m_q[b];
            2'd1: begin
              if (j[b] && !k[b]) exp_q[b] = 1'b1;
              else if (!j[b] && k[b]) exp_q[b] = 1'b0;
              if (j[b] && k[b]) conflict = 1'b1;
            end
            2'd2: exp_q[b] = j[b];
            default: exp_q[b] = j[b] ? !m_q[b] : m_q[b];
          endcase
        end
      end
      exp_chg = exp_q ^ m_q;
      exp_cnt = 0;
      for (int b = 0; b < W; b++) if (exp_q[b] != m_q[b]) exp_cnt++;
      if (conflict) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_q = exp_q;

      tick();
      if (q !== m_q || qn !== ~m_q) begin
        bad++;
        $display("FAIL rnd_q n=%0d got q=%h qn=%h want q=%h", n, q, qn, m_q);
      end
      total++;
      if (changed !== exp_chg || chg_cnt !== 4'(exp_cnt)) begin
        bad++;
        $display("FAIL rnd_changed n=%0d got chg=%h cnt=%0d want chg=%h cnt=%0d",
                 n, changed, chg_cnt, exp_chg, exp_cnt);
      end
      total++;
      if (sr_err !== m_err) begin
        bad++;
        $display("FAIL rnd_sr_err n=%0d got %b want %b", n, sr_err, m_err);
      end
      total++;
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_jk();
    test_sr();
    test_priority();
    test_modes();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
